wasm_linear_memory: RTL and testbench



---
 rtl/wasm_mem_pkg.sv | 32 +++
 rtl/wasm_linear_memory_if.sv | 25 ++
 rtl/mem_byte_align.sv | 54 +++++
 rtl/wasm_linear_memory.sv | 162 ++++++++++++++++
 tb/tb_wasm_linear_memory.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/wasm_mem_pkg.sv
// Shared types and helpers for the byte-addressed Wasm linear memory.
package wasm_mem_pkg;

  // Access size codes carried on cmd_size.
  typedef enum logic [1:0] {
    MEM_SZ_B = 2'd0,
    MEM_SZ_H = 2'd1,
    MEM_SZ_W = 2'd2,
    MEM_SZ_X = 2'd3
  } mem_size_e;

  // Command sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC0 = 2'd1,
    ST_ACC1 = 2'd2,
    ST_DONE = 2'd3
  } mem_state_e;

  // Number of bytes touched by a size code; the illegal code reports zero.
  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    logic [2:0] n;
    case (size)
      MEM_SZ_B: n = 3'd1;
      MEM_SZ_H: n = 3'd2;
      MEM_SZ_W: n = 3'd4;
      default:  n = 3'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/wasm_linear_memory_if.sv
// Command/response bundle between the interpreter core and the linear memory.
interface wasm_linear_memory_if;
  logic        cmd_start;
  logic        cmd_write;
  logic [1:0]  cmd_size;
  logic        cmd_signed;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        cmd_ready;
  logic [31:0] rdata;
  logic        rdata_ready;
  logic        trap;

  // Core side: issues commands, observes completion.
  modport master (
    output cmd_start, cmd_write, cmd_size, cmd_signed, addr, wdata,
    input  cmd_ready, rdata, rdata_ready, trap
  );

  // Memory side: accepts commands, reports completion.
  modport slave (
    input  cmd_start, cmd_write, cmd_size, cmd_signed, addr, wdata,
    output cmd_ready, rdata, rdata_ready, trap
  );
endinterface

// File: rtl/mem_byte_align.sv
// Byte-lane steering: maps a sub-word access at a byte offset onto two
// consecutive storage words (write enables/data) and reassembles loads.
module mem_byte_align
  import wasm_mem_pkg::*;
(
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        is_signed,
  input  logic [31:0] wdata,
  input  logic [31:0] word0,
  input  logic [31:0] word1,
  output logic        straddle,
  output logic [3:0]  be0,
  output logic [3:0]  be1,
  output logic [31:0] wd0,
  output logic [31:0] wd1,
  output logic [31:0] rdata_ext
);

  logic [2:0]  nbytes;
  logic [7:0]  be_span;
  logic [63:0] wd_span;
  logic [31:0] raw;

  // Treat the two words as one 64-bit window and shift the access into place.
  always_comb begin
    nbytes   = size_bytes(size);
    straddle = ({1'b0, offset} + nbytes) > 3'd4;
    case (nbytes)
      3'd1:    be_span = 8'b0000_0001 << offset;
      3'd2:    be_span = 8'b0000_0011 << offset;
      3'd4:    be_span = 8'b0000_1111 << offset;
      default: be_span = 8'b0000_0000;
    endcase
    wd_span = {32'b0, wdata} << {offset, 3'b000};
    raw     = 32'({word1, word0} >> {offset, 3'b000});
    case (size)
      MEM_SZ_B: rdata_ext = {{24{is_signed & raw[7]}}, raw[7:0]};
      MEM_SZ_H: rdata_ext = {{16{is_signed & raw[15]}}, raw[15:0]};
      MEM_SZ_W: rdata_ext = raw;
      default:  rdata_ext = 32'b0;
    endcase
  end

  // Split the 64-bit window into the low (word0) and high (word1) lanes.
  genvar gi;
  for (gi = 0; gi < 4; gi++) begin : g_lane
    assign be0[gi]          = be_span[gi];
    assign be1[gi]          = be_span[gi + 4];
    assign wd0[8*gi +: 8]   = wd_span[8*gi +: 8];
    assign wd1[8*gi +: 8]   = wd_span[32 + 8*gi +: 8];
  end

endmodule

// File: rtl/wasm_linear_memory.sv
// Byte-addressed little-endian linear memory with 8/16/32-bit accesses,
// word-straddling support and a bounds trap, behind a start/ready/done port.
module wasm_linear_memory
  import wasm_mem_pkg::*;
#(
  parameter int MEMORY_SIZE = 2048
) (
  input  logic                clk,
  input  logic                reset,
  wasm_linear_memory_if.slave bus
);

  localparam int          AW       = (MEMORY_SIZE > 1) ? $clog2(MEMORY_SIZE) : 1;
  localparam logic [32:0] CAPACITY = 33'(4 * MEMORY_SIZE);

  mem_state_e state_reg, state_next;

  // Latched command
  logic          write_reg, signed_reg, fault_reg;
  logic [1:0]    size_reg, offset_reg;
  logic [AW-1:0] idx_reg, idx_next;
  logic [31:0]   wdata_reg;

  // Storage and read path
  logic [31:0]   mem [MEMORY_SIZE];
  logic [31:0]   rd_word_reg, lo_word_reg, rdata_reg;
  logic          mem_we, mem_re;
  logic [3:0]    mem_be;
  logic [31:0]   mem_wdata;
  logic [AW-1:0] mem_widx, mem_ridx;

  // Alignment results
  logic          straddle;
  logic [3:0]    be0, be1;
  logic [31:0]   wd0, wd1, rdata_ext, word0;
  logic          fault_in, load_done;

  assign idx_next = idx_reg + AW'(1);

  // Bounds/size check on the incoming command; 33-bit sum so high addresses cannot wrap.
  always_comb begin
    fault_in = (bus.cmd_size == MEM_SZ_X) ||
               (({1'b0, bus.addr} + 33'(size_bytes(bus.cmd_size))) > CAPACITY);
  end

  // Sequencer state register.
  always_ff @(posedge clk) begin
    if (reset) state_reg <= ST_IDLE;
    else       state_reg <= state_next;
  end

  // Sequencer next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (bus.cmd_start) state_next = fault_in ? ST_DONE : ST_ACC0;
      ST_ACC0: state_next = straddle ? ST_ACC1 : ST_DONE;
      ST_ACC1: state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Handshake outputs decoded from state.
  always_comb begin
    bus.cmd_ready   = (state_reg == ST_IDLE);
    bus.rdata_ready = (state_reg == ST_DONE);
    bus.trap        = (state_reg == ST_DONE) && fault_reg;
    bus.rdata       = rdata_reg;
  end

  // Capture the command on accept; later input changes are ignored.
  always_ff @(posedge clk) begin
    if (reset) begin
      write_reg  <= 1'b0;
      signed_reg <= 1'b0;
      fault_reg  <= 1'b0;
      size_reg   <= 2'd0;
      offset_reg <= 2'd0;
      idx_reg    <= '0;
      wdata_reg  <= 32'b0;
    end else if (state_reg == ST_IDLE && bus.cmd_start) begin
      write_reg  <= bus.cmd_write;
      signed_reg <= bus.cmd_signed;
      fault_reg  <= fault_in;
      size_reg   <= bus.cmd_size;
      offset_reg <= bus.addr[1:0];
      idx_reg    <= bus.addr[AW+1:2];
      wdata_reg  <= bus.wdata;
    end
  end

  // In ACC1 the first word was already moved aside; the fresh read is the upper word.
  assign word0 = (state_reg == ST_ACC1) ? lo_word_reg : rd_word_reg;

  mem_byte_align u_align (
    .offset    (offset_reg),
    .size      (size_reg),
    .is_signed (signed_reg),
    .wdata     (wdata_reg),
    .word0     (word0),
    .word1     (rd_word_reg),
    .straddle  (straddle),
    .be0       (be0),
    .be1       (be1),
    .wd0       (wd0),
    .wd1       (wd1),
    .rdata_ext (rdata_ext)
  );

  // Storage port control: the first word is read at accept so its data is ready in ACC0;
  // the second word is read in ACC0. Writes are suppressed by reset so an aborted
  // straddling store leaves the upper word untouched.
  always_comb begin
    mem_we    = 1'b0;
    mem_be    = be0;
    mem_wdata = wd0;
    mem_widx  = idx_reg;
    mem_re    = 1'b0;
    mem_ridx  = bus.addr[AW+1:2];
    case (state_reg)
      ST_IDLE: mem_re = bus.cmd_start && !bus.cmd_write && !fault_in;
      ST_ACC0: begin
        mem_we   = write_reg && !reset;
        mem_re   = !write_reg && straddle;
        mem_ridx = idx_next;
      end
      ST_ACC1: begin
        mem_we    = write_reg && !reset;
        mem_be    = be1;
        mem_wdata = wd1;
        mem_widx  = idx_next;
      end
      default: ;
    endcase
  end

  // Word storage with per-byte-lane write enables and a registered read.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int l = 0; l < 4; l++) begin
        if (mem_be[l]) mem[mem_widx][8*l +: 8] <= mem_wdata[8*l +: 8];
      end
    end
    if (mem_re) rd_word_reg <= mem[mem_ridx];
  end

  // Hold the lower word of a straddling load while the upper word is fetched.
  always_ff @(posedge clk) begin
    if (state_reg == ST_ACC0) lo_word_reg <= rd_word_reg;
  end

  assign load_done = !write_reg &&
                     ((state_reg == ST_ACC0 && !straddle) || state_reg == ST_ACC1);

  // Load result updates only on the transition into DONE, so it is never partial.
  always_ff @(posedge clk) begin
    if (reset)          rdata_reg <= 32'b0;
    else if (load_done) rdata_reg <= rdata_ext;
  end

endmodule

// File: tb/tb_wasm_linear_memory.sv
// Directed scoreboard bench for wasm_linear_memory.
module tb_wasm_linear_memory;

  logic clk = 1'b0;
  logic reset = 1'b1;

  wasm_linear_memory_if bus();

  wasm_linear_memory #(.MEMORY_SIZE(2048)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] rdata;
    logic        trap;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  logic [7:0]  model [int unsigned];
  logic [31:0] last_rdata = 32'h0;
  int          vectors = 0;
  int          miscompares = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Issue one command from an idle point (#1 after a posedge), then check its completion.
  task automatic run_cmd(input logic wr, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd, input string tag);
    exp_t        e;
    int          nb;
    int          n;
    logic        fault;
    logic [32:0] end_addr;
    logic [31:0] raw;
    nb       = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : (sz == 2'd2) ? 4 : 0;
    end_addr = {1'b0, a} + 33'(nb);
    fault    = (sz == 2'd3) || (end_addr > 33'd8192);
    e.tag    = tag;
    e.trap   = fault;
    e.lat    = fault ? 1 : ((int'(a[1:0]) + nb) > 4 ? 3 : 2);
    e.rdata  = last_rdata;
    if (!fault) begin
      if (wr) begin
        for (int i = 0; i < nb; i++) model[a + 32'(i)] = wd[8*i +: 8];
      end else begin
        raw = 32'h0;
        for (int i = 0; i < nb; i++) raw[8*i +: 8] = model[a + 32'(i)];
        if (sg && sz == 2'd0 && raw[7])  raw = raw | 32'hFFFF_FF00;
        if (sg && sz == 2'd1 && raw[15]) raw = raw | 32'hFFFF_0000;
        e.rdata    = raw;
        last_rdata = raw;
      end
    end
    sb.push_back(e);
    bus.cmd_start  = 1'b1;
    bus.cmd_write  = wr;
    bus.cmd_size   = sz;
    bus.cmd_signed = sg;
    bus.addr       = a;
    bus.wdata      = wd;
    @(posedge clk); #1;
    bus.cmd_start  = 1'b0;
    bus.addr       = $urandom;
    bus.wdata      = $urandom;
    bus.cmd_size   = 2'($urandom_range(0, 3));
    n = 1;
    while (bus.rdata_ready !== 1'b1 && n < 8) begin
      @(posedge clk); #1;
      n++;
    end
    e = sb.pop_front();
    check({e.tag, " done"},  32'(bus.rdata_ready), 32'd1);
    check({e.tag, " lat"},   32'(n), 32'(e.lat));
    check({e.tag, " rdata"}, bus.rdata, e.rdata);
    check({e.tag, " trap"},  32'(bus.trap), 32'(e.trap));
    $display("cmd %-14s wr=%0b sz=%0d a=%08h wd=%08h -> rdata=%08h trap=%0b lat=%0d",
             e.tag, wr, sz, a, wd, bus.rdata, bus.trap, n);
    @(posedge clk); #1;
    check({e.tag, " pulse"}, 32'(bus.rdata_ready), 32'd0);
    check({e.tag, " ready"}, 32'(bus.cmd_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int pulses;
    logic [31:0] seen;
    bus.cmd_start  = 1'b0;
    bus.cmd_write  = 1'b0;
    bus.cmd_size   = 2'd0;
    bus.cmd_signed = 1'b0;
    bus.addr       = 32'h0;
    bus.wdata      = 32'h0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("rst ready", 32'(bus.cmd_ready), 32'd1);
    check("rst rdata", bus.rdata, 32'h0);
    check("rst done",  32'(bus.rdata_ready), 32'd0);
    check("rst trap",  32'(bus.trap), 32'd0);

    // Aligned word and byte lanes
    run_cmd(1, 2'd2, 0, 32'h10, 32'h1122_3344, "st_w_10");
    run_cmd(0, 2'd2, 0, 32'h10, 32'h0, "ld_w_10");
    run_cmd(0, 2'd0, 0, 32'h10, 32'h0, "ld_b_10");
    run_cmd(0, 2'd0, 0, 32'h13, 32'h0, "ld_b_13");
    run_cmd(1, 2'd0, 0, 32'h11, 32'h0000_00AA, "st_b_11");
    run_cmd(0, 2'd2, 0, 32'h10, 32'h0, "ld_w_10b");
    // Sign extension
    run_cmd(1, 2'd1, 0, 32'h20, 32'h0000_8001, "st_h_20");
    run_cmd(0, 2'd1, 1, 32'h20, 32'h0, "ld_hs_20");
    run_cmd(0, 2'd1, 0, 32'h20, 32'h0, "ld_hu_20");
    run_cmd(0, 2'd0, 1, 32'h21, 32'h0, "ld_bs_21");
    // Straddling accesses
    run_cmd(1, 2'd2, 0, 32'h04, 32'h0, "clr_04");
    run_cmd(1, 2'd2, 0, 32'h08, 32'h0, "clr_08");
    run_cmd(1, 2'd2, 0, 32'h0C, 32'h0, "clr_0c");
    run_cmd(1, 2'd2, 0, 32'h07, 32'hDEAD_BEEF, "st_w_07");
    run_cmd(0, 2'd2, 0, 32'h07, 32'h0, "ld_w_07");
    run_cmd(0, 2'd2, 0, 32'h04, 32'h0, "ld_w_04");
    run_cmd(0, 2'd2, 0, 32'h08, 32'h0, "ld_w_08");
    run_cmd(1, 2'd1, 0, 32'h0B, 32'h0000_CAFE, "st_h_0b");
    run_cmd(0, 2'd1, 0, 32'h0B, 32'h0, "ld_h_0b");
    run_cmd(0, 2'd2, 0, 32'h08, 32'h0, "ld_w_08b");
    // Bounds
    run_cmd(1, 2'd0, 0, 32'h1FFF, 32'h0000_005A, "st_b_1fff");
    run_cmd(0, 2'd0, 0, 32'h1FFF, 32'h0, "ld_b_1fff");
    run_cmd(0, 2'd2, 0, 32'h1FFD, 32'h0, "ld_w_1ffd");
    run_cmd(0, 2'd3, 0, 32'h0, 32'h0, "ld_sz3");
    run_cmd(0, 2'd2, 0, 32'hFFFF_FFFF, 32'h0, "ld_w_top");
    run_cmd(1, 2'd2, 0, 32'h1FFE, 32'h1234_5678, "st_w_1ffe");
    run_cmd(1, 2'd2, 0, 32'h1FFC, 32'h0A0B_0C0D, "st_w_1ffc");
    run_cmd(0, 2'd2, 0, 32'h1FFC, 32'h0, "ld_w_1ffc");
    run_cmd(0, 2'd1, 1, 32'h1FFE, 32'h0, "ld_hs_1ffe");

    // cmd_start held while busy, inputs changed after accept: exactly one command runs
    pulses = 0;
    seen   = 32'h0;
    bus.cmd_start  = 1'b1;
    bus.cmd_write  = 1'b0;
    bus.cmd_size   = 2'd2;
    bus.cmd_signed = 1'b0;
    bus.addr       = 32'h10;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (k == 0) begin
        bus.cmd_write = 1'b1;
        bus.addr      = 32'h20;
        bus.wdata     = 32'hFFFF_FFFF;
      end
      if (k == 1) bus.cmd_start = 1'b0;
      if (bus.rdata_ready === 1'b1) begin
        pulses++;
        seen = bus.rdata;
      end
    end
    last_rdata = 32'h1122_AA44;
    check("hold pulses", 32'(pulses), 32'd1);
    check("hold rdata",  seen, 32'h1122_AA44);
    $display("hold-start load: pulses=%0d rdata=%08h", pulses, seen);
    run_cmd(0, 2'd2, 0, 32'h20, 32'h0, "ld_hs_chk");
    run_cmd(0, 2'd2, 0, 32'h10, 32'h0, "ld_w_10c");

    // Reset during ACC1 of a straddling store
    pulses = 0;
    bus.cmd_start  = 1'b1;
    bus.cmd_write  = 1'b1;
    bus.cmd_size   = 2'd2;
    bus.cmd_signed = 1'b0;
    bus.addr       = 32'h0E;
    bus.wdata      = 32'h5566_7788;
    @(posedge clk); #1;
    bus.cmd_start = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort ready", 32'(bus.cmd_ready), 32'd1);
    check("abort rdata", bus.rdata, 32'h0);
    for (int k = 0; k < 4; k++) begin
      if (bus.rdata_ready === 1'b1) pulses++;
      @(posedge clk); #1;
    end
    check("abort pulses", 32'(pulses), 32'd0);
    $display("reset in ACC1: ready=%0b rdata=%08h pulses=%0d", bus.cmd_ready, bus.rdata, pulses);
    last_rdata      = 32'h0;
    model[32'h0E]   = 8'h88;
    model[32'h0F]   = 8'h77;
    run_cmd(0, 2'd2, 0, 32'h0C, 32'h0, "ld_w_0c");
    run_cmd(0, 2'd2, 0, 32'h10, 32'h0, "ld_w_10d");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
